// File: rtl/stft_pkg.sv
// Shared helpers for the STFT datapath blocks: signed saturating add.
package stft_pkg;

    // Widest sample the saturating helper handles; callers sign-extend into it.
    localparam int unsigned SAT_W = 32;

    typedef logic signed [SAT_W-1:0] sat_word_t;
    typedef logic signed [SAT_W:0]   sat_wide_t;

    // Signed add of two w-bit values clamped to [-2^(w-1), 2^(w-1)-1].
    // Operands arrive sign-extended to SAT_W; the result is sign-extended too.
    function automatic sat_word_t sat_add(input sat_word_t a, input sat_word_t b,
                                          input int unsigned w);
        sat_wide_t sum;
        sat_wide_t hi;
        sat_wide_t lo;
        sum = sat_wide_t'(a) + sat_wide_t'(b);
        hi  = (sat_wide_t'(1) <<< (w - 1)) - sat_wide_t'(1);
        lo  = -hi - sat_wide_t'(1);
        if (sum > hi) begin
            return sat_word_t'(hi);
        end
        if (sum < lo) begin
            return sat_word_t'(lo);
        end
        return sat_word_t'(sum);
    endfunction

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module ram_1r1w_sync #(
    parameter int unsigned width_p      = 16,
    parameter int unsigned els_p        = 8,
    parameter int unsigned addr_width_p = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic                    r_v_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);

    logic [width_p-1:0] mem [els_p];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    // Registered read port; returns old data on a same-address write.
    always_ff @(posedge clk_i) begin
        if (r_v_i) begin
            r_data_o <= mem[r_addr_i];
        end
    end

endmodule

// File: rtl/overlap_add.sv
// 50% overlap-add reconstruction: first half of each frame plus the stored
// second half of the previous frame, one output per first-half sample.
module overlap_add #(
    parameter int unsigned width_p = 16,
    parameter int unsigned hop_p   = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic signed [width_p-1:0] data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic signed [width_p-1:0] data_o,
    input  logic                      ready_i
);

    import stft_pkg::*;

    localparam int unsigned frame_lp  = 2 * hop_p;
    localparam int unsigned idx_w_lp  = $clog2(frame_lp);
    localparam int unsigned addr_w_lp = $clog2(hop_p);

    localparam logic [idx_w_lp-1:0] hop_idx_lp  = idx_w_lp'(hop_p);
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(frame_lp - 1);

    logic [idx_w_lp-1:0]       idx_q;
    logic [idx_w_lp-1:0]       idx_d;
    logic                      first_q;
    logic                      phase_a;
    logic                      accept;
    logic                      emit;
    logic                      wr_en;
    logic [addr_w_lp-1:0]      wr_addr;
    logic [addr_w_lp-1:0]      rd_addr;
    logic [width_p-1:0]        rd_data;
    logic signed [width_p-1:0] tail;
    logic signed [width_p-1:0] sum_d;

    // Handshake, next index, RAM addressing and the saturated overlap sum.
    always_comb begin
        phase_a = 1'b0;
        ready_o = 1'b1;
        accept  = 1'b0;
        emit    = 1'b0;
        idx_d   = idx_q;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        tail    = '0;
        sum_d   = '0;

        phase_a = (idx_q < hop_idx_lp);
        // The output register is only needed while producing first-half sums.
        ready_o = phase_a ? (!valid_o || ready_i) : 1'b1;
        accept  = valid_i && ready_o && !reset_i;
        emit    = valid_o && ready_i;

        if (reset_i) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = (idx_q == last_idx_lp) ? '0 : idx_q + idx_w_lp'(1);
        end

        // Prefetch the tail for the upcoming index so it is ready on accept.
        rd_addr = (idx_d >= hop_idx_lp) ? addr_w_lp'(idx_d - hop_idx_lp)
                                        : addr_w_lp'(idx_d);

        wr_en   = accept && !phase_a;
        wr_addr = addr_w_lp'(idx_q - hop_idx_lp);

        // No previous frame exists until the first wrap.
        tail  = first_q ? '0 : rd_data;
        sum_d = width_p'(sat_add(SAT_W'(data_i), SAT_W'(tail), width_p));
    end

    // Frame index and first-frame flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q   <= '0;
            first_q <= 1'b1;
        end else begin
            idx_q <= idx_d;
            if (accept && (idx_q == last_idx_lp)) begin
                first_q <= 1'b0;
            end
        end
    end

    // Output register: load on a first-half accept, otherwise drain on emit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (accept && phase_a) begin
            valid_o <= 1'b1;
            data_o  <= sum_d;
        end else if (emit) begin
            valid_o <= 1'b0;
        end
    end

    ram_1r1w_sync #(
        .width_p (width_p),
        .els_p   (hop_p)
    ) tail_mem (
        .clk_i    (clk_i),
        .w_v_i    (wr_en),
        .w_addr_i (wr_addr),
        .w_data_i (data_i),
        .r_v_i    (1'b1),
        .r_addr_i (rd_addr),
        .r_data_o (rd_data)
    );

endmodule

// File: tb/tb_overlap_add.sv
// Directed bench for overlap_add with width 8, hop 4.
module tb_overlap_add;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;

    logic                clk = 1'b0;
    logic                reset_i;
    logic signed [W-1:0] data_i;
    logic                valid_i;
    logic                ready_o;
    logic                valid_o;
    logic signed [W-1:0] data_o;
    logic                ready_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit rnd   = 1'b0;
    int got[$];
    int want[$];

    overlap_add #(.width_p(W), .hop_p(H)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    // Cycle counter for throughput checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted sample; inputs are stable from negedge to posedge.
    always @(negedge clk) begin
        if (!reset_i && valid_o && ready_i) got.push_back(int'(data_o));
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Offer one sample and return #1 after the edge that accepts it.
    task automatic push(input int v);
        int n;
        data_i = 8'(v);
        if (rnd) begin
            while ($urandom_range(0, 2) == 0) begin
                valid_i = 1'b0;
                ready_i = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        valid_i = 1'b1;
        n = 0;
        forever begin
            if (rnd) ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ready_o) break;
            n++;
            if (n > 500) begin
                chk("push_timeout", 0, 1);
                valid_i = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input int f[8]);
        foreach (f[i]) push(f[i]);
    endtask

    task automatic want4(input int a, input int b, input int c, input int d);
        want.push_back(a); want.push_back(b); want.push_back(c); want.push_back(d);
    endtask

    // Let pending output drain, then compare collected against expected.
    task automatic drain_cmp(input string tag);
        int n;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, got.size(), want.size());
        n = (got.size() < want.size()) ? got.size() : want.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), got[i], want[i]);
        got.delete();
        want.delete();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f[8];
        int t[4];
        int c0;
        int x;

        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_data", int'(data_o), 0);
        chk("reset_ready", int'(ready_o), 1);

        // First frame: raw first half, one cycle after accept.
        push(1);
        chk("lat_valid", int'(valid_o), 1);
        chk("lat_data", int'(data_o), 1);
        for (int i = 2; i <= 8; i++) push(i);
        want4(1, 2, 3, 4);
        drain_cmp("frame1");

        // Overlap with back-to-back throughput.
        f = '{10, 10, 10, 10, 10, 10, 10, 10};
        c0 = cyc;
        send(f);
        chk("thru_cycles", cyc - c0, 8);
        want4(15, 16, 17, 18);
        drain_cmp("frame2");

        f = '{0, 0, 0, 0, 0, 0, 0, 0};
        send(f);
        want4(10, 10, 10, 10);
        drain_cmp("frame3");

        // Saturation: load tail, then add against it.
        f = '{0, 0, 0, 0, 100, -100, 27, 0};
        send(f);
        want4(0, 0, 0, 0);
        drain_cmp("sat_load");
        f = '{100, -100, 100, 5, 0, 0, 0, 0};
        send(f);
        want4(127, -128, 127, 5);
        drain_cmp("sat");

        // Backpressure in the first half.
        ready_i = 1'b0;
        push(1);
        data_i = 8'(2);
        valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", int'(ready_o), 0);
            chk("bp_valid", int'(valid_o), 1);
            chk("bp_data", int'(data_o), 1);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        push(2); push(3); push(4);
        // Second half is accepted while the output is still stalled.
        ready_i = 1'b0;
        data_i = 8'(20);
        @(negedge clk);
        chk("bp_phaseb_ready", int'(ready_o), 1);
        @(posedge clk); #1;
        push(30); push(40); push(50);
        chk("bp_hold_valid", int'(valid_o), 1);
        chk("bp_hold_data", int'(data_o), 4);
        want4(1, 2, 3, 4);
        drain_cmp("bp");
        f = '{0, 0, 0, 0, 0, 0, 0, 0};
        send(f);
        want4(20, 30, 40, 50);
        drain_cmp("bp_tail");

        // Random gaps on both sides against a reference model.
        rnd = 1'b1;
        t = '{0, 0, 0, 0};
        for (int fr = 0; fr < 50; fr++) begin
            for (int i = 0; i < 8; i++) begin
                x = int'($urandom_range(0, 255)) - 128;
                push(x);
                if (i < 4) want.push_back(clamp8(x + t[i]));
                else t[i-4] = x;
            end
        end
        rnd = 1'b0;
        drain_cmp("random");

        // Reset at index 5 of frame 2 with an output still pending.
        do_reset();
        for (int i = 1; i <= 8; i++) push(i);
        push(10); push(10); push(10); push(10);
        ready_i = 1'b0;
        push(10);
        do_reset();
        chk("rst_mid_valid", int'(valid_o), 0);
        chk("rst_mid_data", int'(data_o), 0);
        want4(1, 2, 3, 4);
        want.push_back(15); want.push_back(16); want.push_back(17);
        drain_cmp("pre_rst");
        for (int i = 1; i <= 8; i++) push(i);
        want4(1, 2, 3, 4);
        drain_cmp("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/overlap_add.md
# overlap_add

Synthesis-side counterpart of the STFT analysis delay buffer. It consumes time-domain frames of `2*hop_p` samples from the inverse-transform path, at 50 % overlap. It adds the first half of each frame to the stored second half of the previous frame and emits `hop_p` reconstructed samples per frame. The stored half lives in a synchronous 1R1W RAM. Both sides use a ready/valid stream handshake.

## Interface
- `width_p`, default 16: signed sample width, in and out.
- `hop_p`, default 8: hop length. Frame length is `2*hop_p`. Must be ≥ 2.
- `clk_i`, in, 1: clock. Single clock domain.
- `reset_i`, in, 1: synchronous, active-high reset.
- `data_i`, in, `width_p`: signed frame sample, in frame order.
- `valid_i`, in, 1: `data_i` is valid.
- `ready_o`, out, 1: block accepts `data_i` this cycle.
- `valid_o`, out, 1: `data_o` holds a reconstructed sample.
- `data_o`, out, `width_p`: signed output sample, registered.
- `ready_i`, in, 1: downstream accepts `data_o`.

## Operation
- Accept means `valid_i & ready_o`. Emit means `valid_o & ready_i`.
- Frame index `idx_q` counts 0..`2*hop_p-1`. It advances by 1 on each accept and wraps to 0 after `2*hop_p-1`.
- Phase A, `idx_q < hop_p`:
  - The accepted sample s produces `sat(s + tail[idx_q])` into the output register.
  - `valid_o` is set on the next cycle.
- Phase B, `idx_q ≥ hop_p`:
  - The accepted sample is written to `tail[idx_q - hop_p]`.
  - Nothing is emitted and the output register is untouched.
- `first_q` is set by reset and cleared on the wrap from `2*hop_p-1` to 0. While it is set, the tail term is forced to 0, so the first frame emits its raw first half.
- `sat()` is a signed `width_p+1`-bit sum clamped to [−2^(width_p−1), 2^(width_p−1)−1].
- The tail of the final frame is never emitted. It is discarded by reset.

## Timing
- Reset values:
  - `valid_o` = 0, `data_o` = 0.
  - `idx_q` = 0, `first_q` = 1.
  - `ready_o` = 1.
- `ready_o`:
  - Phase A: `!valid_o | ready_i`.
  - Phase B: 1, since the output register is not needed.
- Output register:
  - Loads on a Phase A accept.
  - Otherwise `valid_o` clears on emit.
  - A simultaneous emit and Phase A accept reloads it and keeps `valid_o` = 1.
- Latency is 1 cycle from a Phase A accept to `valid_o`. Throughput is one sample per cycle in both phases with `ready_i` held high.
- RAM prefetch:
  - Read address = `idx_d` (next index, `mod hop_p` in Phase A), with reads enabled every cycle.
  - RAM output therefore holds `tail[idx_q]` one cycle after any index change.
  - Reading on the Phase B→A wrap (addr 0) never collides with the write at addr `hop_p-1`, because `hop_p ≥ 2`.
- Write enable = Phase B accept, with address `idx_q - hop_p`.
- A `valid_i` deassertion mid-frame pauses `idx_q`. The partial frame resumes on the next accept.
- Reset mid-frame:
  - Drops the in-flight output and clears `idx_q` and `first_q` state.
  - The next input sample is treated as sample 0 of a first frame.

## Structure
- `stft_pkg` holds the shared signed saturating-add function, reused by the other STFT datapath blocks.
- Tail storage is one `ram_1r1w_sync` instance: width `width_p`, depth `hop_p`, no init file.
- `idx_q` width is `$clog2(2*hop_p)`. RAM address width is `$clog2(hop_p)`.
- No other sub-modules.

## Test plan
All scenarios use `width_p`=8, `hop_p`=4.
- **First frame:** after reset, stream 1..8 with `ready_i`=1 → `data_o` 1,2,3,4, each 1 cycle after its accept; no output for 5..8.
- **Overlap:** follow with a frame of all 10 → outputs 15,16,17,18. A third frame of all 0 → outputs 10,10,10,10.
- **Saturation:**
  - Tail 100 plus first half 100 → 127.
  - Tail −100 plus −100 → −128.
  - Tail 27 plus 100 → 127, with no wrap to negative.
- **Backpressure:** hold `ready_i`=0 during Phase A → `ready_o` drops after one output is pending and `data_o` stays stable. In Phase B, `ready_o`=1 and samples are accepted regardless of `ready_i`. No samples are lost or duplicated.
- **Throughput:** random `valid_i` and `ready_i` gaps over 50 frames → the output sequence matches a reference overlap-add model sample-for-sample.
- **Reset mid-frame:** assert `reset_i` at index 5 of frame 2 → `valid_o`=0 the next cycle. The following frame 1..8 emits 1,2,3,4, with the old tail ignored.
